// File: rtl/pe_weight_loader_pkg.sv
// Shared encodings and default widths for the PE-side weight loaders.
package pe_weight_loader_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int LEN_WIDTH  = 16;
    localparam int DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/pe_weight_loader_if.sv
// Load command and weight stream bundle between the DMA side and the loader.
interface pe_weight_loader_if
    import pe_weight_loader_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int LW = LEN_WIDTH,
    parameter int DW = DATA_WIDTH
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base_addr;
    logic [LW-1:0] cmd_len;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;

    modport master (
        output cmd_valid, cmd_base_addr, cmd_len, s_data, s_valid,
        input  cmd_ready, s_ready
    );

    modport slave (
        input  cmd_valid, cmd_base_addr, cmd_len, s_data, s_valid,
        output cmd_ready, s_ready
    );
endinterface

// File: rtl/pe_weight_loader.sv
// Streams a counted block of words into one PE weight port at consecutive
// addresses, reporting busy/done/aborted to the layer scheduler.
module pe_weight_loader
    import pe_weight_loader_pkg::*;
#(
    parameter int AW = ADDR_WIDTH,
    parameter int LW = LEN_WIDTH,
    parameter int DW = DATA_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    pe_weight_loader_if.slave   bus,
    input  logic                abort,
    output logic [DW-1:0]       weight_wr_data,
    output logic [AW-1:0]       weight_wr_addr,
    output logic                weight_wr_en,
    output logic                busy,
    output logic                done,
    output logic                aborted
);

    state_t        state;
    logic [AW-1:0] addr_cnt;
    logic [LW-1:0] rem_cnt;

    // Handshake readiness depends on state only, never on the valids.
    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.s_ready   = (state == ST_LOAD);
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            addr_cnt       <= '0;
            rem_cnt        <= '0;
            weight_wr_en   <= 1'b0;
            weight_wr_data <= '0;
            weight_wr_addr <= '0;
            done           <= 1'b0;
            aborted        <= 1'b0;
        end else begin
            weight_wr_en <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        addr_cnt <= bus.cmd_base_addr;
                        rem_cnt  <= bus.cmd_len;
                        if (bus.cmd_len == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    // Abort wins over a word offered in the same cycle.
                    if (abort) begin
                        state   <= ST_IDLE;
                        aborted <= 1'b1;
                    end else if (bus.s_valid) begin
                        weight_wr_en   <= 1'b1;
                        weight_wr_data <= bus.s_data;
                        weight_wr_addr <= addr_cnt;
                        addr_cnt       <= addr_cnt + 1'b1;
                        rem_cnt        <= rem_cnt - 1'b1;
                        if (rem_cnt == LW'(1)) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pe_weight_loader.sv
// Directed cycle-table bench for pe_weight_loader.
module tb_pe_weight_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        abort;
    logic [31:0] weight_wr_data;
    logic [31:0] weight_wr_addr;
    logic        weight_wr_en;
    logic        busy;
    logic        done;
    logic        aborted;

    pe_weight_loader_if #(.AW(32), .LW(16), .DW(32)) bus ();

    pe_weight_loader #(.AW(32), .LW(16), .DW(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .abort          (abort),
        .weight_wr_data (weight_wr_data),
        .weight_wr_addr (weight_wr_addr),
        .weight_wr_en   (weight_wr_en),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        cv;
        logic [31:0] base;
        logic [15:0] len;
        logic        sv;
        logic [31:0] sd;
        logic        ab;
    } in_t;

    typedef struct packed {
        logic        en;
        logic [31:0] addr;
        logic [31:0] data;
        logic        dn;
        logic        abt;
        logic        bsy;
        logic        crdy;
        logic        srdy;
    } out_t;

    typedef struct packed {
        in_t  in;
        out_t exp;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(
        input logic cv, input logic [31:0] base, input logic [15:0] len,
        input logic sv, input logic [31:0] sd, input logic ab,
        input logic en, input logic [31:0] a, input logic [31:0] d,
        input logic dn, input logic abt, input logic bsy,
        input logic cr, input logic sr
    );
        vec_t v;
        v.in  = '{cv, base, len, sv, sd, ab};
        v.exp = '{en, a, d, dn, abt, bsy, cr, sr};
        vecs.push_back(v);
    endtask

    function automatic out_t sample();
        out_t o;
        o = '{weight_wr_en, weight_wr_addr, weight_wr_data, done,
              aborted, busy, bus.cmd_ready, bus.s_ready};
        return o;
    endfunction

    task automatic drive(input in_t i);
        bus.cmd_valid     = i.cv;
        bus.cmd_base_addr = i.base;
        bus.cmd_len       = i.len;
        bus.s_valid       = i.sv;
        bus.s_data        = i.sd;
        abort             = i.ab;
    endtask

    task automatic check(input string name, input out_t act, input out_t exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got en=%b addr=%h data=%h done=%b abt=%b busy=%b crdy=%b srdy=%b, want en=%b addr=%h data=%h done=%b abt=%b busy=%b crdy=%b srdy=%b",
                name, act.en, act.addr, act.data, act.dn, act.abt, act.bsy,
                act.crdy, act.srdy, exp.en, exp.addr, exp.data, exp.dn,
                exp.abt, exp.bsy, exp.crdy, exp.srdy);
        end
    endtask

    // Apply inputs for one cycle and check what is visible in that cycle.
    task automatic step(input string name, input in_t i, input out_t exp);
        @(negedge clk);
        drive(i);
        #1;
        check(name, sample(), exp);
    endtask

    localparam logic [31:0] WF = 32'hFFFF_FFFE;

    initial begin
        in_t  idle_in;
        idle_in = '0;
        drive(idle_in);
        rst = 1'b1;

        // cv base len sv sd ab | en addr data done abt busy crdy srdy
        // base=23 len=4, back-to-back
        add(1, 23, 4, 0, 0,   0,  0, 0,  0,   0, 0, 0, 1, 0);
        add(0, 0,  0, 1, 'hA, 0,  0, 0,  0,   0, 0, 1, 0, 1);
        add(0, 0,  0, 1, 'hB, 0,  1, 23, 'hA, 0, 0, 1, 0, 1);
        add(0, 0,  0, 1, 'hC, 0,  1, 24, 'hB, 0, 0, 1, 0, 1);
        add(0, 0,  0, 1, 'hD, 0,  1, 25, 'hC, 0, 0, 1, 0, 1);
        add(0, 0,  0, 0, 0,   0,  1, 26, 'hD, 1, 0, 1, 0, 0);
        add(0, 0,  0, 0, 0,   0,  0, 26, 'hD, 0, 0, 0, 1, 0);
        // base=100 len=3 with bubbles
        add(1, 100, 3, 0, 0,    0, 0, 26,  'hD,  0, 0, 0, 1, 0);
        add(0, 0,   0, 1, 'h11, 0, 0, 26,  'hD,  0, 0, 1, 0, 1);
        add(0, 0,   0, 0, 0,    0, 1, 100, 'h11, 0, 0, 1, 0, 1);
        add(0, 0,   0, 1, 'h22, 0, 0, 100, 'h11, 0, 0, 1, 0, 1);
        add(0, 0,   0, 0, 0,    0, 1, 101, 'h22, 0, 0, 1, 0, 1);
        add(0, 0,   0, 1, 'h33, 0, 0, 101, 'h22, 0, 0, 1, 0, 1);
        add(0, 0,   0, 0, 0,    0, 1, 102, 'h33, 1, 0, 1, 0, 0);
        add(0, 0,   0, 0, 0,    0, 0, 102, 'h33, 0, 0, 0, 1, 0);
        // len=0, abort during DONE ignored
        add(1, 5, 0, 0, 0, 0, 0, 102, 'h33, 0, 0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 1, 0, 102, 'h33, 1, 0, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 102, 'h33, 0, 0, 0, 1, 0);
        // cmd with abort in IDLE accepted; abort on 3rd handshake
        add(1, 'h40, 8, 0, 0,    1, 0, 102,  'h33, 0, 0, 0, 1, 0);
        add(0, 0,    0, 1, 'h51, 0, 0, 102,  'h33, 0, 0, 1, 0, 1);
        add(0, 0,    0, 1, 'h52, 0, 1, 'h40, 'h51, 0, 0, 1, 0, 1);
        add(0, 0,    0, 1, 'h53, 1, 1, 'h41, 'h52, 0, 0, 1, 0, 1);
        add(0, 0,    0, 0, 0,    0, 0, 'h41, 'h52, 0, 1, 0, 1, 0);
        add(0, 0,    0, 0, 0,    0, 0, 'h41, 'h52, 0, 0, 0, 1, 0);
        // address wrap, cmd_valid held while busy is ignored
        add(1, WF,    3, 0, 0,    0, 0, 'h41, 'h52, 0, 0, 0, 1, 0);
        add(1, 'h999, 9, 1, 'h61, 0, 0, 'h41, 'h52, 0, 0, 1, 0, 1);
        add(1, 'h999, 9, 1, 'h62, 0, 1, WF,   'h61, 0, 0, 1, 0, 1);
        add(1, 'h999, 9, 1, 'h63, 0, 1, WF+1, 'h62, 0, 0, 1, 0, 1);
        add(0, 0,     0, 0, 0,    0, 1, 0,    'h63, 1, 0, 1, 0, 0);
        add(0, 0,     0, 0, 0,    0, 0, 0,    'h63, 0, 0, 0, 1, 0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", sample(), '{0, 0, 0, 0, 0, 0, 1, 0});
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            step($sformatf("row%0d", i), vecs[i].in, vecs[i].exp);

        // Reset between 2nd and 3rd write of a len=5 load
        step("rst_cmd", '{1, 'h200, 5, 0, 0, 0},
             '{0, 0, 'h63, 0, 0, 0, 1, 0});
        step("rst_w1", '{0, 0, 0, 1, 'h81, 0},
             '{0, 0, 'h63, 0, 0, 1, 0, 1});
        step("rst_w2", '{0, 0, 0, 1, 'h82, 0},
             '{1, 'h200, 'h81, 0, 0, 1, 0, 1});
        @(negedge clk);
        drive('{0, 0, 0, 1, 'h83, 0});
        rst = 1'b1;
        #1;
        check("rst_pre", sample(), '{1, 'h201, 'h82, 0, 0, 1, 0, 1});
        step("rst_clear", '{0, 0, 0, 1, 'h84, 0},
             '{0, 0, 0, 0, 0, 0, 1, 0});
        rst = 1'b0;
        step("rst_nowr", '{1, 7, 1, 0, 0, 0},
             '{0, 0, 0, 0, 0, 0, 1, 0});
        step("new_load", '{0, 0, 0, 1, 'h77, 0},
             '{0, 0, 0, 0, 0, 1, 0, 1});
        step("new_write", '{0, 0, 0, 0, 0, 0},
             '{1, 7, 'h77, 1, 0, 1, 0, 0});
        step("new_idle", '{0, 0, 0, 0, 0, 0},
             '{0, 7, 'h77, 0, 0, 0, 1, 0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
